// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch sequencer: PC owner, single-outstanding imem requester, decode hand-off
//
// Purpose:
//   Issues one instruction-memory request at a time from the PC, buffers the
//   returned word and presents {if_pc, if_instruction} to decode. Redirects
//   from the control unit take priority in every state. Halt lets the current
//   word finish, then the block parks in IDLE.
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous active-low reset
//   halt            stop issuing new fetches once the current word is done
//   redirect_valid  load word-aligned redirect_pc as the next fetch PC
//   redirect_pc     redirect target
//   imem_req_*      request handshake to instruction memory (addr = pc)
//   imem_resp_*     in-order response word, one per accepted request
//   if_*            registered hand-off to decode (valid/ready)
//   busy            low only while parked in IDLE
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   Adds perf_fetched (decode handshakes) and perf_stall (stall cycles).

module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [31:0]       imem_resp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_instruction,
    output logic              busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_fetched,
    output logic [CNT_W-1:0]  perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc;
    // Set when the outstanding request belongs to a path that was redirected
    // away from; its response must be discarded.
    logic              squash;

    logic [ADDR_W-1:0] redirect_target;
    logic              accept;
    logic              handshake;
    logic              capture;
    logic              unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign accept               = (state == S_REQ) && imem_req_ready;
    // A redirect in HOLD kills the word even if decode is ready that cycle.
    assign handshake            = (state == S_HOLD) && if_ready && !redirect_valid;
    assign capture              = (state == S_WAIT) && (next_state == S_HOLD);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (!halt) next_state = S_REQ;
            end
            S_REQ: begin
                // A redirect with the request accepted still has to wait for
                // the stale response, which squash will drop.
                if (imem_req_ready) next_state = S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (squash || redirect_valid) begin
                        next_state = halt ? S_IDLE : S_REQ;
                    end else begin
                        next_state = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid || if_ready) begin
                    next_state = halt ? S_IDLE : S_REQ;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req_valid = (state == S_REQ);
        imem_req_addr  = pc;
        busy           = (state != S_IDLE);
    end

    // PC, squash flag and registered decode outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc             <= RESET_PC;
            squash         <= 1'b0;
            if_valid       <= 1'b0;
            if_pc          <= '0;
            if_instruction <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_target;
            end else if (handshake) begin
                pc <= pc + ADDR_W'(4);
            end

            // The response retires the outstanding request, squashed or not.
            if ((state == S_WAIT) && imem_resp_valid) begin
                squash <= 1'b0;
            end else if (redirect_valid && ((state == S_WAIT) || accept)) begin
                squash <= 1'b1;
            end

            if_valid <= (next_state == S_HOLD);
            if (capture) begin
                if_pc          <= pc;
                if_instruction <= imem_resp_data;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic stall_cycle;

    assign stall_cycle = ((state == S_REQ) && !imem_req_ready) ||
                         (state == S_WAIT) ||
                         ((state == S_HOLD) && !if_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (handshake)   perf_fetched <= perf_fetched + CNT_W'(1);
            if (stall_cycle) perf_stall   <= perf_stall + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer with randomized memory/decode timing

module tb_fetch_sequencer;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .CNT_W    (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .halt            (halt),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instruction  (if_instruction),
        .busy            (busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_stall      (perf_stall)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: next PC expected on the decode stream, and the
    // memory's view of the single outstanding request.
    logic [31:0] exp_pc;
    bit          pending;
    logic [31:0] pend_addr;
    int          delivered;
    int          stall_cnt;
    int          cyc;
    int          last_del;
    bit          chk_tput;

    // Stimulus knobs (percent probabilities) and redirect/halt controls.
    int          p_ready;
    int          p_ifr;
    int          p_resp;
    bit          rd_req;
    logic [31:0] rd_target;
    bit          halt_v;

    // Previous-cycle request state for the stability rule.
    bit          prev_hold;
    bit          prev_redir;
    logic [31:0] prev_addr;
    logic [31:0] prev_target;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_wait();
        return busy && !imem_req_valid && !if_valid;
    endfunction

    function automatic bit cond(input int kind);
        case (kind)
            0:       return in_wait();
            1:       return if_valid;
            2:       return !busy;
            default: return imem_req_valid;
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, imem_req_valid, 0);
        check({tag, "_req_addr"},  imem_req_addr,  RESET_PC);
        check({tag, "_if_valid"},  if_valid,       0);
        check({tag, "_if_pc"},     if_pc,          0);
        check({tag, "_if_instr"},  if_instruction, 0);
        check({tag, "_busy"},      busy,           0);
    endtask

    // One clock cycle, entered and left at a falling edge. Outputs depend only
    // on registered state, so the upcoming rising-edge event is fully known here.
    task automatic cycle();
        bit accepted;
        if (prev_hold) begin
            check("req_stable_valid", imem_req_valid, 1);
            check("req_stable_addr", imem_req_addr, prev_redir ? prev_target : prev_addr);
        end
        imem_req_ready  = ($urandom_range(99) < p_ready);
        if_ready        = ($urandom_range(99) < p_ifr);
        redirect_valid  = rd_req;
        redirect_pc     = rd_target;
        halt            = halt_v;
        imem_resp_valid = pending && ($urandom_range(99) < p_resp);
        imem_resp_data  = imem_resp_valid ? mem_word(pend_addr) : $urandom;

        if ((imem_req_valid && !imem_req_ready) || in_wait() || (if_valid && !if_ready))
            stall_cnt++;

        accepted = imem_req_valid && imem_req_ready;
        if (accepted) begin
            check("one_outstanding", pending, 0);
            if (!redirect_valid) check("req_addr", imem_req_addr, exp_pc);
        end
        if (imem_resp_valid) pending = 0;

        if (redirect_valid) begin
            exp_pc = {rd_target[31:2], 2'b00};
        end else if (if_valid && if_ready) begin
            check("if_pc", if_pc, exp_pc);
            check("if_instruction", if_instruction, mem_word(exp_pc));
            if (chk_tput && last_del >= 0) check("throughput", cyc - last_del, 3);
            last_del = cyc;
            delivered++;
            exp_pc = exp_pc + 32'd4;
        end

        if (accepted) begin
            pending   = 1;
            pend_addr = imem_req_addr;
        end
        prev_hold   = imem_req_valid && !imem_req_ready;
        prev_redir  = redirect_valid;
        prev_addr   = imem_req_addr;
        prev_target = {rd_target[31:2], 2'b00};

        @(posedge clk);
        cyc++;
        @(negedge clk);
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, delivered);
        check("perf_stall", perf_stall, stall_cnt);
`endif
    endtask

    task automatic wait_for(input int kind, input string tag);
        int n = 0;
        while (!cond(kind) && n < 60) begin
            cycle();
            n++;
        end
        check(tag, cond(kind), 1);
    endtask

    task automatic redirect_pulse(input logic [31:0] target);
        rd_req    = 1;
        rd_target = target;
        cycle();
        rd_req    = 0;
    endtask

    task automatic model_reset();
        exp_pc    = RESET_PC;
        pending   = 0;
        delivered = 0;
        stall_cnt = 0;
        prev_hold = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hpc;
        int          d0;
        int          n;

        reset = 1'b0;
        halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        if_ready = 1'b0;
        p_ready = 100; p_ifr = 100; p_resp = 100;
        rd_req = 0; rd_target = '0; halt_v = 0;
        chk_tput = 0; last_del = -1; cyc = 0;
        model_reset();

        // Reset values
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Zero-wait stream: 0,4,8 at one per 3 cycles
        chk_tput = 1;
        last_del = -1;
        n = 0;
        while (delivered < 3 && n < 20) begin
            cycle();
            n++;
        end
        check("t1_count", delivered, 3);
        chk_tput = 0;

        // Request held 4 cycles without ready, then a single acceptance
        wait_for(3, "t2_in_req");
        p_ready = 0;
        repeat (4) cycle();
        check("t2_still_req", imem_req_valid, 1);
        p_ready = 100;
        cycle();
        check("t2_no_dup", imem_req_valid, 0);

        // Redirect in WAIT: stale word dropped, target aligned
        p_resp = 0;
        wait_for(0, "t3_in_wait");
        redirect_pulse(32'h0000_0103);
        p_resp = 100;
        wait_for(1, "t3_hold");
        check("t3_if_pc", if_pc, 32'h0000_0100);

        // Redirect in HOLD with decode ready: word dropped, no handshake
        redirect_pulse(32'h0000_2000);
        check("t4_dropped", if_valid, 0);
        check("t4_req_valid", imem_req_valid, 1);
        check("t4_req_addr", imem_req_addr, 32'h0000_2000);

        // Halt during WAIT: word delivered, then parked; resume at pc+4
        p_resp = 0;
        wait_for(0, "t5_in_wait");
        halt_v = 1;
        p_resp = 100;
        wait_for(1, "t5_hold");
        hpc = if_pc;
        cycle();
        wait_for(2, "t5_idle");
        repeat (3) cycle();
        check("t5_parked_busy", busy, 0);
        check("t5_parked_req", imem_req_valid, 0);
        halt_v = 0;
        wait_for(3, "t5_resume");
        check("t5_resume_addr", imem_req_addr, hpc + 32'd4);

        // PC wrap
        redirect_pulse(32'hFFFF_FFFC);
        wait_for(1, "t6_hold");
        check("t6_if_pc", if_pc, 32'hFFFF_FFFC);
        cycle();
        wait_for(3, "t6_req");
        check("t6_wrap_addr", imem_req_addr, 32'h0000_0000);

        // Randomized timing, redirects and halts
        d0 = delivered;
        for (int blk = 0; blk < 30; blk++) begin
            p_ready = $urandom_range(100, 20);
            p_ifr   = $urandom_range(100, 20);
            p_resp  = $urandom_range(100, 20);
            for (int i = 0; i < 100; i++) begin
                rd_req    = ($urandom_range(15) == 0);
                rd_target = $urandom;
                if ($urandom_range(39) == 0) halt_v = ~halt_v;
                cycle();
            end
        end
        rd_req = 0;
        halt_v = 0;
        check("rand_progress", (delivered - d0) > 50, 1);

        // Reset mid-operation with a response arriving during reset
        p_ready = 100; p_ifr = 100; p_resp = 0;
        wait_for(0, "rst_in_wait");
        #2;
        reset = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("midrst_held");
        reset = 1'b1;
        imem_resp_valid = 1'b0;
        model_reset();
        p_resp = 100;
        wait_for(3, "post_rst_req");
        check("post_rst_addr", imem_req_addr, RESET_PC);
        wait_for(1, "post_rst_hold");
        check("post_rst_if_pc", if_pc, RESET_PC);
        check("post_rst_instr", if_instruction, mem_word(RESET_PC));
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
